// File: rtl/rms_src_if.sv
// rms_src amplitude request channel.
// One-deep valid/ready slot carrying the commanded RMS code.
interface rms_src_if #(
   parameter int W = 11
);
   logic [W-1:0] v_rms_set;
   logic         set_valid;
   logic         set_ready;

   modport master (
      output v_rms_set,
      output set_valid,
      input  set_ready
   );

   modport slave (
      input  v_rms_set,
      input  set_valid,
      output set_ready
   );
endinterface

// File: rtl/rms_src.sv
// rms_src: zero-mean square wave whose frame RMS equals the active code.
// Optional output muting is built with RMS_SRC_MUTE_EN.
module rms_src #(
   parameter int data_bit_width = 12,
   parameter int bit_points     = 8
) (
   input  logic                             clk_fs,
   input  logic                             rst_n,
   rms_src_if.slave                         set,
`ifdef RMS_SRC_MUTE_EN
   input  logic                             mute,
`endif
   output logic signed [data_bit_width-1:0] data_s,
   output logic [data_bit_width-2:0]        amp_active,
   output logic                             irq
);

   localparam int AW = data_bit_width - 1;
   localparam int CW = bit_points;

   localparam logic [CW-1:0] LAST    = '1;
   localparam logic [CW-1:0] HALF_M1 = LAST >> 1;
   localparam logic [CW-1:0] ONE     = CW'(1);

   logic [CW-1:0] cnt;
   logic [AW-1:0] pending;
   logic          full;
   logic          muted;
   logic          boundary;
   logic          take;

   logic signed [data_bit_width-1:0] pos;
   logic signed [data_bit_width-1:0] neg;
   logic signed [data_bit_width-1:0] sample;

   assign boundary      = (cnt == LAST);
   assign take          = set.set_valid & ~full;
   assign set.set_ready = ~full;

   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) cnt <= '0;
      else        cnt <= cnt + ONE;
   end

   // A slot filled on the boundary edge waits for the next boundary.
   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         full       <= 1'b0;
         amp_active <= '0;
      end else if (take) begin
         pending <= set.v_rms_set;
         full    <= 1'b1;
      end else if (boundary && full) begin
         amp_active <= pending;
         full       <= 1'b0;
      end
   end

`ifdef RMS_SRC_MUTE_EN
   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n)        muted <= 1'b0;
      else if (boundary) muted <= mute;
   end
`else
   assign muted = 1'b0;
`endif

   assign pos = {1'b0, amp_active};
   assign neg = -pos;

   always_comb begin
      sample = '0;
      if (!muted) sample = cnt[CW-1] ? neg : pos;
   end

   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n) data_s <= '0;
      else        data_s <= sample;
   end

   always_ff @(posedge clk_fs or negedge rst_n) begin
      if (!rst_n)              irq <= 1'b0;
      else if (cnt == HALF_M1) irq <= 1'b0;
      else if (cnt == ONE)     irq <= 1'b1;
   end

endmodule

// File: tb/tb_rms_src.sv
// Directed bench for rms_src (12-bit samples, 256-sample frames).
// Mute scenario runs only when built with RMS_SRC_MUTE_EN.
module tb_rms_src;

   logic clk_fs = 1'b0;
   logic rst_n  = 1'b0;
   logic signed [11:0] data_s;
   logic [10:0]        amp_active;
   logic               irq;
`ifdef RMS_SRC_MUTE_EN
   logic mute = 1'b0;
`endif

   rms_src_if #(.W(11)) sif ();

   rms_src #(
      .data_bit_width (12),
      .bit_points     (8)
   ) dut (
      .clk_fs     (clk_fs),
      .rst_n      (rst_n),
      .set        (sif),
`ifdef RMS_SRC_MUTE_EN
      .mute       (mute),
`endif
      .data_s     (data_s),
      .amp_active (amp_active),
      .irq        (irq)
   );

   always #5 clk_fs = ~clk_fs;

   int errors = 0;
   int checks = 0;
   int ph     = 0;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cnt=%0d)", tag, got, exp, ph);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk_fs);
         #1;
         ph = (ph + 1) % 256;
      end
   endtask

   task automatic go_to(input int target);
      tick((target - ph + 256) % 256);
   endtask

   // Walk one frame from the current cnt==0 point; k0 skips samples seen.
   task automatic frame(input int a, input int k0, input string tag);
      longint s  = 0;
      longint sq = 0;
      int     e;
      for (int k = 1; k < k0; k++) begin
         e = (k <= 128) ? a : -a;
         s += e;
         sq += e * e;
      end
      for (int k = k0; k <= 256; k++) begin
         tick(1);
         e = (k <= 128) ? a : -a;
         chk(tag, int'(data_s), e);
         s += data_s;
         sq += int'(data_s) * int'(data_s);
      end
      chk({tag, "_mean"}, int'(s), 0);
      chk({tag, "_msq"}, int'(sq / 256), a * a);
   endtask

   initial begin
      int guard;
      sif.v_rms_set = '0;
      sif.set_valid = 1'b0;

      #2;
      chk("rst_data", int'(data_s), 0);
      chk("rst_amp", int'(amp_active), 0);
      chk("rst_ready", int'(sif.set_ready), 1);
      chk("rst_irq", int'(irq), 0);
      @(negedge clk_fs);
      @(negedge clk_fs);
      rst_n = 1'b1;
      ph = 0;

      for (int i = 0; i < 1000; i++) begin
         tick(1);
         chk("idle_data", int'(data_s), 0);
         chk("idle_ready", int'(sif.set_ready), 1);
         chk("idle_irq", int'(irq), int'(ph >= 2 && ph <= 127));
      end

      go_to(50);
      sif.v_rms_set = 11'd1000;
      sif.set_valid = 1'b1;
      tick(1);
      sif.set_valid = 1'b0;
      chk("req_ready_low", int'(sif.set_ready), 0);
      chk("req_amp_hold", int'(amp_active), 0);
      go_to(0);
      chk("apply_amp", int'(amp_active), 1000);
      chk("apply_ready", int'(sif.set_ready), 1);
      chk("apply_data_old", int'(data_s), 0);
      frame(1000, 1, "f1000");
      chk("neg_code", int'(data_s & 12'hFFF), 32'hC18);

      go_to(255);
      sif.v_rms_set = 11'd2047;
      sif.set_valid = 1'b1;
      tick(1);
      sif.set_valid = 1'b0;
      chk("late_amp_hold", int'(amp_active), 1000);
      chk("late_ready", int'(sif.set_ready), 0);
      frame(1000, 1, "f_late_old");
      chk("late_amp", int'(amp_active), 2047);
      frame(2047, 1, "f2047");
      chk("neg_full", int'(data_s & 12'hFFF), 32'h801);

      go_to(10);
      sif.v_rms_set = 11'd300;
      sif.set_valid = 1'b1;
      tick(1);
      sif.v_rms_set = 11'd400;
      chk("b2b_ready_low", int'(sif.set_ready), 0);
      guard = 0;
      while (sif.set_ready !== 1'b1 && guard < 400) begin
         tick(1);
         guard++;
      end
      chk("b2b_wait_bound", int'(guard < 400), 1);
      chk("b2b_reopen_phase", ph, 0);
      chk("b2b_amp300", int'(amp_active), 300);
      tick(1);
      sif.set_valid = 1'b0;
      chk("b2b_taken", int'(sif.set_ready), 0);
      chk("f300", int'(data_s), 300);
      frame(300, 2, "f300");
      chk("b2b_amp400", int'(amp_active), 400);
      frame(400, 1, "f400");

      go_to(100);
      sif.v_rms_set = 11'd700;
      sif.set_valid = 1'b1;
      tick(1);
      sif.set_valid = 1'b0;
      go_to(180);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_data", int'(data_s), 0);
      chk("arst_amp", int'(amp_active), 0);
      chk("arst_ready", int'(sif.set_ready), 1);
      chk("arst_irq", int'(irq), 0);
      @(negedge clk_fs);
      rst_n = 1'b1;
      ph = 0;
      for (int i = 0; i < 300; i++) begin
         tick(1);
         chk("post_rst_data", int'(data_s), 0);
         chk("post_rst_amp", int'(amp_active), 0);
      end

`ifdef RMS_SRC_MUTE_EN
      sif.v_rms_set = 11'd500;
      sif.set_valid = 1'b1;
      tick(1);
      sif.set_valid = 1'b0;
      go_to(255);
      mute = 1'b1;
      tick(1);
      mute = 1'b0;
      chk("mute_amp", int'(amp_active), 500);
      frame(0, 1, "f_muted");
      frame(500, 1, "f_unmuted");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
